// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Trial subtraction goes through the shared external ripple adder.
module seq_divider #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_r,
    input  logic         add_c
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_n;
    logic [N-1:0]   rem, q, dvs;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   shifted, rem_n, q_n;
    logic           msb, ok;

    // The bit shifted out of rem means the trial value is >= 2^N, so the
    // subtraction cannot borrow and add_r mod 2^N is already the remainder.
    always_comb begin
        shifted = {rem[N-2:0], q[N-1]};
        msb     = rem[N-1];
        ok      = add_c | msb;
        rem_n   = ok ? add_r : shifted;
        q_n     = {q[N-2:0], ok};
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = shifted;
            add_b   = dvs;
            add_cin = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (divisor == '0) ? DONE : RUN;
            RUN:     if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            rem         <= '0;
                            q           <= dividend;
                            dvs         <= divisor;
                            cnt         <= CW'(N - 1);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_n;
                    q   <= q_n;
                    cnt <= cnt - CW'(1);
                    // Publish on the last iteration so results are valid with done.
                    if (cnt == '0) begin
                        quotient  <= q_n;
                        remainder <= rem_n;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider with a behavioural model of the shared adder.
module tb_seq_divider;
    localparam int N = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0, divisor = '0;
    logic         busy, done, div_by_zero, add_cin, add_c;
    logic [N-1:0] quotient, remainder, add_a, add_b, add_r;

    seq_divider #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_r(add_r), .add_c(add_c)
    );

    always #5 clk = ~clk;

    always_comb {add_c, add_r} = {1'b0, add_a} + {1'b0, ~add_b} + {{N{1'b0}}, add_cin};

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           t0;
        int           nbusy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, bcnt = 0;
    logic [N-1:0] last_q, last_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy) bcnt++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("dbz", 32'(div_by_zero), 32'(e.dbz));
                chk("latency", 32'(cyc - e.t0 + 1), e.dbz ? 32'd1 : 32'(N + 1));
                chk("busy_cycles", 32'(bcnt), 32'(e.nbusy));
                chk("busy_with_done", 32'(busy), 32'd0);
            end
        end
    end

    // Drive one start pulse; the model result is queued only when the start will be accepted.
    task automatic go(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1; dividend = a; divisor = b;
        if (push) begin
            e.dbz   = (b == '0);
            e.q     = e.dbz ? '1 : a / b;
            e.r     = e.dbz ? a : a % b;
            e.t0    = cyc + 1;
            e.nbusy = e.dbz ? 0 : N;
            last_q  = e.q;
            last_r  = e.r;
            bcnt    = 0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_q"}, 32'(quotient), 32'd0);
        chk({tag, "_r"}, 32'(remainder), 32'd0);
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
        chk({tag, "_adda"}, 32'(add_a), 32'd0);
        chk({tag, "_addb"}, 32'(add_b), 32'd0);
        chk({tag, "_cin"}, 32'(add_cin), 32'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        go(24'd100, 24'd7, 1'b1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", 32'(quotient), 32'(last_q));
        chk("hold_r", 32'(remainder), 32'(last_r));

        go(24'hFFFFFF, 24'h800001, 1'b1);
        drain();
        go(24'hFFFFFF, 24'd1, 1'b1);
        drain();
        go(24'd10, 24'd20, 1'b1);
        drain();
        go(24'd5, 24'd0, 1'b1);
        drain();

        // Second start lands mid-RUN and must be ignored.
        go(24'd50, 24'd3, 1'b1);
        repeat (4) @(posedge clk);
        go(24'd9, 24'd9, 1'b0);
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("hold2_q", 32'(quotient), 32'd16);
        chk("hold2_r", 32'(remainder), 32'd2);

        // Reset in the middle of a division: immediate clear and no done.
        go(24'd1000, 24'd3, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_done", 32'(done), 32'd0);

        go(24'd1000, 24'd3, 1'b1);
        drain();

        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] a, b;
            a = N'($urandom);
            b = N'($urandom_range(1, 4095));
            if (i[0]) b = N'($urandom) | 24'h1;
            go(a, b, 1'b1);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
